// File: rtl/upcount.sv
// -----------------------------------------------------------------------------
// upcount -- parameterised binary up-counter
//
// A generic leaf counter for event/cycle counting, timers and address
// generation. One register bank plus next-state logic, no combinational path
// from any input to Q.
//
// Parameters:
//   WIDTH   bit width of the load value R and the count Q (minimum 1)
//
// Ports (order fixed for positional instantiation):
//   R       in   WIDTH  parallel load value, sampled on the rising Clock edge
//   Resetn  in   1      asynchronous active-low reset, clears Q immediately
//   Clock   in   1      system clock, all non-reset state changes on rising edge
//   E       in   1      count enable, active high
//   L       in   1      synchronous parallel load, active high, wins over E
//   Q       out  WIDTH  current count, driven straight from the register
// -----------------------------------------------------------------------------
module upcount #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] R,
  input  logic             Resetn,
  input  logic             Clock,
  input  logic             E,
  input  logic             L,
  output logic [WIDTH-1:0] Q
);

  logic [WIDTH-1:0] count;

  // Load has priority over enable. Written as if/else on L then E so that an
  // unknown control value falls through to the "not taken" branch. The
  // increment is plain WIDTH-bit unsigned arithmetic: the carry-out is
  // dropped, so all ones wraps to zero.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      count <= '0;
    end else if (L) begin
      count <= R;
    end else if (E) begin
      count <= count + 1'b1;
    end
  end

  assign Q = count;

endmodule

// File: tb/tb_upcount.sv
// -----------------------------------------------------------------------------
// tb_upcount -- directed bench for upcount at WIDTH = 4, 1 and 8.
// All three instances share Clock and Resetn; each has its own R/E/L.
// Inputs change 1 time unit after the rising edge, outputs are checked there.
// -----------------------------------------------------------------------------
module tb_upcount;

  logic       Clock;
  logic       Resetn;

  logic [3:0] r4, q4;
  logic       e4, l4;
  logic [0:0] r1, q1;
  logic       e1, l1;
  logic [7:0] r8, q8;
  logic       e8, l8;

  int checks;
  int errors;

  upcount #(.WIDTH(4)) dut4 (
    .R(r4), .Resetn(Resetn), .Clock(Clock), .E(e4), .L(l4), .Q(q4)
  );

  upcount #(.WIDTH(1)) dut1 (
    .R(r1), .Resetn(Resetn), .Clock(Clock), .E(e1), .L(l1), .Q(q1)
  );

  upcount #(.WIDTH(8)) dut8 (
    .R(r8), .Resetn(Resetn), .Clock(Clock), .E(e8), .L(l8), .Q(q8)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic chk4(input string tag, input logic [3:0] exp);
    checks++;
    assert (q4 === exp) else begin
      errors++;
      $error("FAIL %s: Q observed %0h expected %0h", tag, q4, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic [0:0] exp);
    checks++;
    assert (q1 === exp) else begin
      errors++;
      $error("FAIL %s: Q observed %0h expected %0h", tag, q1, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] exp);
    checks++;
    assert (q8 === exp) else begin
      errors++;
      $error("FAIL %s: Q observed %0h expected %0h", tag, q8, exp);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;

    // 1. Reset held across an edge with load and enable both active.
    Resetn = 1'b0;
    r4 = 4'd5;  e4 = 1'b1; l4 = 1'b1;
    r1 = 1'b1;  e1 = 1'b1; l1 = 1'b1;
    r8 = 8'h33; e8 = 1'b1; l8 = 1'b1;
    step();
    chk4("reset_held_w4", 4'd0);
    chk1("reset_held_w1", 1'b0);
    chk8("reset_held_w8", 8'h00);

    // Get a nonzero Q, then drop reset mid-cycle.
    Resetn = 1'b1;
    r4 = 4'd9; l4 = 1'b1; e4 = 1'b0;
    e1 = 1'b0; l1 = 1'b0;
    e8 = 1'b0; l8 = 1'b0;
    step();
    chk4("load_9", 4'd9);
    #2 Resetn = 1'b0;
    #1;
    chk4("async_reset_midcycle", 4'd0);

    // 2. Release and count.
    #1 Resetn = 1'b1;
    l4 = 1'b0; e4 = 1'b1;
    step(); chk4("count_1", 4'd1);
    step(); chk4("count_2", 4'd2);
    step(); chk4("count_3", 4'd3);
    l4 = 1'b1; r4 = 4'd14;
    step(); chk4("load_14", 4'd14);
    l4 = 1'b0;
    step(); chk4("count_15", 4'd15);
    step(); chk4("wrap_15_to_0", 4'd0);

    // 3. Load wins over enable; R changes between edges are ignored.
    l4 = 1'b1; e4 = 1'b1; r4 = 4'b1101;
    step(); chk4("load_over_enable", 4'd13);
    l4 = 1'b0;
    step(); chk4("count_14", 4'd14);
    #2 r4 = 4'b1111;
    #1 chk4("r_change_no_effect", 4'd14);
    step(); chk4("count_15_b", 4'd15);

    // 4. Hold, then async reset between edges that persists with E=1.
    e4 = 1'b0;
    step(); chk4("hold_15_a", 4'd15);
    step(); chk4("hold_15_b", 4'd15);
    step(); chk4("hold_15_c", 4'd15);
    #2 Resetn = 1'b0;
    #1 chk4("async_reset_from_15", 4'd0);
    e4 = 1'b1; l4 = 1'b1;
    step(); chk4("reset_dominates_a", 4'd0);
    step(); chk4("reset_dominates_b", 4'd0);

    // 5. One-cycle load pulse, count, load while counting.
    #1 Resetn = 1'b1;
    l4 = 1'b1; e4 = 1'b0; r4 = 4'b1000;
    step(); chk4("load_8", 4'd8);
    l4 = 1'b0; e4 = 1'b1;
    step(); chk4("count_9", 4'd9);
    step(); chk4("count_10", 4'd10);
    l4 = 1'b1; r4 = 4'd3;
    step(); chk4("load_while_counting", 4'd3);
    l4 = 1'b0;
    step(); chk4("count_4", 4'd4);

    // Unknown controls behave as 0.
    l4 = 1'bx; e4 = 1'b0; r4 = 4'd12;
    step(); chk4("l_unknown_no_load", 4'd4);
    l4 = 1'b0; e4 = 1'bx;
    step(); chk4("e_unknown_no_count", 4'd4);
    e4 = 1'b0;

    // 6. WIDTH=1 toggles, WIDTH=8 wraps and loads.
    e1 = 1'b1;
    step(); chk1("w1_toggle_1", 1'b1);
    step(); chk1("w1_toggle_0", 1'b0);
    step(); chk1("w1_toggle_1b", 1'b1);
    e1 = 1'b0;
    step(); chk1("w1_hold", 1'b1);

    l8 = 1'b1; r8 = 8'hFE;
    step(); chk8("w8_load_fe", 8'hFE);
    l8 = 1'b0; e8 = 1'b1;
    step(); chk8("w8_count_ff", 8'hFF);
    step(); chk8("w8_wrap_00", 8'h00);
    step(); chk8("w8_count_01", 8'h01);
    l8 = 1'b1; r8 = 8'hA5;
    step(); chk8("w8_load_a5", 8'hA5);
    l8 = 1'b0; e8 = 1'b0;
    step(); chk8("w8_hold_a5", 8'hA5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
